// File: rtl/lcd_pkg.sv
// Shared definitions for the UART-to-LCD row staging path.
// Holds the default geometry of a display row/frame, the host ACK byte,
// and the bank-select type used by the ping-pong row buffer.
package lcd_pkg;

    // Default geometry: 240 px x 2 B (RGB565) per row, 320 rows per frame.
    localparam int          ROW_BYTES_DEF      = 480;
    localparam int          ROWS_PER_FRAME_DEF = 320;
    localparam logic [7:0]  ACK_BYTE_DEF       = 8'h41;

    // Two banks, so a single bit selects between them.
    localparam int BANK_W = 1;
    typedef logic [BANK_W-1:0] bank_t;

endpackage : lcd_pkg

// File: rtl/row_bank_ram.sv
// Simple dual-port RAM holding two row banks of bytes.
// Ports:
//   clk    - system clock
//   rst    - synchronous active-high reset (clears the read data register only)
//   we     - write enable
//   waddr  - write address {bank, byte address}
//   wdata  - write data byte
//   raddr  - read address {bank, byte address}
//   rdata  - read data, registered, valid one cycle after raddr
// Addresses are {bank, addr}, so each bank occupies 2^ADDR_W words; words at
// or above the row length are simply never written. The array has no reset
// so it maps onto block RAM.
module row_bank_ram
    import lcd_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [BANK_W+ADDR_W-1:0] waddr,
    input  logic [7:0]               wdata,
    input  logic [BANK_W+ADDR_W-1:0] raddr,
    output logic [7:0]               rdata
);

    localparam int DEPTH = 2 ** (BANK_W + ADDR_W);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    // Write port: one byte per enabled cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read port: registered output, one-cycle latency, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 8'h00;
        end else begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule : row_bank_ram

// File: rtl/uart_row_pingpong.sv
// Packs UART RX bytes into two ping-pong row banks for the LCD engine.
// The host streams row N+1 into one bank while the LCD engine reads row N
// from the other. One ACK byte per released row provides host flow control;
// a byte arriving with both banks full is dropped and flagged as overrun.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   rx_valid, rx_data   - one-cycle RX byte strobe and data
//   rd_addr, rd_data    - byte read from the presented bank, 1-cycle latency
//   row_ready           - presented bank holds a complete row
//   row_done            - LCD engine finished the presented bank
//   row_index           - frame row number of the presented bank
//   frame_done          - pulse when the last row of a frame is released
//   tx_valid, tx_data   - ACK request to UART TX, held until accepted
//   tx_ready            - TX accepts when tx_valid && tx_ready
//   overrun             - sticky: byte arrived with both banks full
module uart_row_pingpong
    import lcd_pkg::*;
#(
    parameter int         ROW_BYTES      = ROW_BYTES_DEF,
    parameter int         ROWS_PER_FRAME = ROWS_PER_FRAME_DEF,
    parameter int         ADDR_W         = 9,
    parameter int         ROW_W          = 9,
    parameter logic [7:0] ACK_BYTE       = ACK_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              row_ready,
    input  logic              row_done,
    output logic [ROW_W-1:0]  row_index,
    output logic              frame_done,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(ROW_BYTES - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS_PER_FRAME - 1);
    localparam logic [1:0]        ACK_MAX  = 2'd2;

    // Architectural state
    logic [ADDR_W-1:0] wr_ptr_q,    wr_ptr_d;
    bank_t             wr_bank_q,   wr_bank_d;
    bank_t             rd_bank_q,   rd_bank_d;
    logic [1:0]        full_q,      full_d;
    logic [ROW_W-1:0]  row_index_q, row_index_d;
    logic [1:0]        ack_pend_q,  ack_pend_d;
    logic              overrun_q,   overrun_d;

    // Registered outputs
    logic              row_ready_q;
    logic              frame_done_q;
    logic              tx_valid_q;
    logic [7:0]        tx_data_q;

    // Combinational strobes
    logic              ram_we_s;
    logic              release_s;
    logic              accept_s;
    logic              frame_pulse_s;

    // Next-state logic for the write path, bank release, row counter and ACK count.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        full_d        = full_q;
        row_index_d   = row_index_q;
        ack_pend_d    = ack_pend_q;
        overrun_d     = overrun_q;
        ram_we_s      = 1'b0;
        frame_pulse_s = 1'b0;

        // row_ready_q mirrors full_q[rd_bank_q], so this is "release a full bank".
        release_s = row_done && row_ready_q;
        accept_s  = tx_valid_q && tx_ready;

        // Write path. The write bank can only be full when both banks are full,
        // because the writer moves on only after filling a bank.
        if (rx_valid) begin
            if (!full_q[wr_bank_q]) begin
                ram_we_s = 1'b1;
                if (wr_ptr_q == LAST_PTR) begin
                    full_d[wr_bank_q] = 1'b1;
                    wr_ptr_d          = {ADDR_W{1'b0}};
                    wr_bank_d         = ~wr_bank_q;
                end else begin
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                end
            end else begin
                overrun_d = 1'b1;
            end
        end else begin
            overrun_d = overrun_q;
        end

        // Release path. Touches the read bank's flag only; the write path above
        // never completes the full read bank, so both updates can coexist.
        if (release_s) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            if (row_index_q == LAST_ROW) begin
                row_index_d   = {ROW_W{1'b0}};
                frame_pulse_s = 1'b1;
            end else begin
                row_index_d = row_index_q + ROW_W'(1);
            end
        end else begin
            rd_bank_d = rd_bank_q;
        end

        // Pending ACK counter: release adds one, TX accept removes one.
        case ({release_s, accept_s})
            2'b10: begin
                if (ack_pend_q != ACK_MAX) begin
                    ack_pend_d = ack_pend_q + 2'd1;
                end else begin
                    ack_pend_d = ack_pend_q;
                end
            end
            2'b01: begin
                if (ack_pend_q != 2'd0) begin
                    ack_pend_d = ack_pend_q - 2'd1;
                end else begin
                    ack_pend_d = ack_pend_q;
                end
            end
            default: begin
                ack_pend_d = ack_pend_q;
            end
        endcase
    end

    // State and output registers. Status outputs are registered from next-state
    // values so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= {ADDR_W{1'b0}};
            wr_bank_q    <= '0;
            rd_bank_q    <= '0;
            full_q       <= 2'b00;
            row_index_q  <= {ROW_W{1'b0}};
            ack_pend_q   <= 2'd0;
            overrun_q    <= 1'b0;
            row_ready_q  <= 1'b0;
            frame_done_q <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= ACK_BYTE;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            full_q       <= full_d;
            row_index_q  <= row_index_d;
            ack_pend_q   <= ack_pend_d;
            overrun_q    <= overrun_d;
            row_ready_q  <= full_d[rd_bank_d];
            frame_done_q <= frame_pulse_s;
            tx_valid_q   <= (ack_pend_d != 2'd0);
            tx_data_q    <= ACK_BYTE;
        end
    end

    row_bank_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we_s),
        .waddr ({wr_bank_q, wr_ptr_q}),
        .wdata (rx_data),
        .raddr ({rd_bank_q, rd_addr}),
        .rdata (rd_data)
    );

    assign row_ready  = row_ready_q;
    assign row_index  = row_index_q;
    assign frame_done = frame_done_q;
    assign tx_valid   = tx_valid_q;
    assign tx_data    = tx_data_q;
    assign overrun    = overrun_q;

endmodule : uart_row_pingpong

// File: tb/tb_uart_row_pingpong.sv
// Directed self-checking bench for uart_row_pingpong with a 4-byte row and
// a 3-row frame.
module tb_uart_row_pingpong;

    localparam int ROW_BYTES      = 4;
    localparam int ROWS_PER_FRAME = 3;
    localparam int ADDR_W         = 2;
    localparam int ROW_W          = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [7:0]        rd_data;
    logic              row_ready;
    logic              row_done = 1'b0;
    logic [ROW_W-1:0]  row_index;
    logic              frame_done;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready = 1'b0;
    logic              overrun;

    int checks = 0;
    int errors = 0;

    uart_row_pingpong #(
        .ROW_BYTES      (ROW_BYTES),
        .ROWS_PER_FRAME (ROWS_PER_FRAME),
        .ADDR_W         (ADDR_W),
        .ROW_W          (ROW_W),
        .ACK_BYTE       (8'h41)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .row_ready  (row_ready),
        .row_done   (row_done),
        .row_index  (row_index),
        .frame_done (frame_done),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .overrun    (overrun)
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    // Advance one clock; inputs set afterwards are sampled at the next edge,
    // outputs read afterwards reflect the edge just taken.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        row_done = 1'b0;
        tx_ready = 1'b0;
        rd_addr  = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic pulse_row_done();
        row_done = 1'b1;
        step();
        row_done = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
        checks++; if (row_ready !== 1'b0) begin errors++; $display("FAIL reset_row_ready got %b want 0", row_ready); end
        checks++; if (row_index !== 2'd0) begin errors++; $display("FAIL reset_row_index got %0d want 0", row_index); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
        checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL reset_tx_data got %h want 41", tx_data); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    endtask

    task automatic test_single_row();
        logic [7:0] exp;
        do_reset();
        for (int i = 0; i < 3; i++) send_byte(8'h10 + 8'(i));
        checks++; if (row_ready !== 1'b0) begin errors++; $display("FAIL row1_partial_ready got %b want 0", row_ready); end
        send_byte(8'h13);
        checks++; if (row_ready !== 1'b1) begin errors++; $display("FAIL row1_ready got %b want 1", row_ready); end
        for (int a = 0; a < 4; a++) begin
            rd_addr = ADDR_W'(a);
            step();
            exp = 8'h10 + 8'(a);
            checks++; if (rd_data !== exp) begin errors++; $display("FAIL row1_read[%0d] got %h want %h", a, rd_data, exp); end
        end
        checks++; if (row_index !== 2'd0) begin errors++; $display("FAIL row1_index got %0d want 0", row_index); end
    endtask

    task automatic test_overrun();
        logic [7:0] exp;
        do_reset();
        for (int i = 0; i < 8; i++) send_byte(8'hA0 + 8'(i));
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_before got %b want 0", overrun); end
        send_byte(8'hEE);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b want 1", overrun); end
        for (int a = 0; a < 4; a++) begin
            rd_addr = ADDR_W'(a);
            step();
            exp = 8'hA0 + 8'(a);
            checks++; if (rd_data !== exp) begin errors++; $display("FAIL ovr_bank0[%0d] got %h want %h", a, rd_data, exp); end
        end
        pulse_row_done();
        checks++; if (row_ready !== 1'b1) begin errors++; $display("FAIL ovr_bank1_ready got %b want 1", row_ready); end
        for (int a = 0; a < 4; a++) begin
            rd_addr = ADDR_W'(a);
            step();
            exp = 8'hA4 + 8'(a);
            checks++; if (rd_data !== exp) begin errors++; $display("FAIL ovr_bank1[%0d] got %h want %h", a, rd_data, exp); end
        end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", overrun); end
    endtask

    task automatic test_ack_handshake();
        int accepts;
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(8'h20 + 8'(i));
        pulse_row_done();
        checks++; if (row_ready !== 1'b0) begin errors++; $display("FAIL ack_ready_clear got %b want 0", row_ready); end
        for (int c = 0; c < 5; c++) begin
            checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL ack_hold_valid[%0d] got %b want 1", c, tx_valid); end
            checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL ack_hold_data[%0d] got %h want 41", c, tx_data); end
            step();
        end
        tx_ready = 1'b1;
        accepts  = 0;
        for (int c = 0; c < 4; c++) begin
            if (tx_valid === 1'b1) accepts++;
            step();
        end
        tx_ready = 1'b0;
        checks++; if (accepts !== 1) begin errors++; $display("FAIL ack_accepts got %0d want 1", accepts); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL ack_drained got %b want 0", tx_valid); end
    endtask

    task automatic test_frame();
        logic [1:0] exp_idx;
        logic       exp_fd;
        do_reset();
        tx_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) send_byte(8'(r * 16 + i));
            exp_idx = 2'(r);
            checks++; if (row_index !== exp_idx) begin errors++; $display("FAIL frame_index[%0d] got %0d want %0d", r, row_index, exp_idx); end
            pulse_row_done();
            exp_fd = (r == 2);
            checks++; if (frame_done !== exp_fd) begin errors++; $display("FAIL frame_done_pulse[%0d] got %b want %b", r, frame_done, exp_fd); end
            step();
            checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL frame_done_low[%0d] got %b want 0", r, frame_done); end
        end
        checks++; if (row_index !== 2'd0) begin errors++; $display("FAIL frame_wrap got %0d want 0", row_index); end
        tx_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(8'h30 + 8'(i));
        for (int i = 0; i < 3; i++) send_byte(8'h40 + 8'(i));
        // Final byte of bank 1 lands in the same cycle bank 0 is released.
        row_done = 1'b1;
        send_byte(8'h43);
        row_done = 1'b0;
        checks++; if (row_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", row_ready); end
        checks++; if (row_index !== 2'd1) begin errors++; $display("FAIL b2b_index got %0d want 1", row_index); end
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL b2b_tx_valid got %b want 1", tx_valid); end
        for (int a = 0; a < 4; a++) begin
            rd_addr = ADDR_W'(a);
            step();
            exp = 8'h40 + 8'(a);
            checks++; if (rd_data !== exp) begin errors++; $display("FAIL b2b_read[%0d] got %h want %h", a, rd_data, exp); end
        end
    endtask

    task automatic test_idle_row_done();
        do_reset();
        pulse_row_done();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL idle_tx_valid got %b want 0", tx_valid); end
        checks++; if (row_index !== 2'd0) begin errors++; $display("FAIL idle_index got %0d want 0", row_index); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL idle_frame_done got %b want 0", frame_done); end
        checks++; if (row_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %b want 0", row_ready); end
        // After one real release the next bank is empty: another pulse must be ignored.
        for (int i = 0; i < 4; i++) send_byte(8'h55);
        pulse_row_done();
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        pulse_row_done();
        step();
        checks++; if (row_index !== 2'd1) begin errors++; $display("FAIL idle2_index got %0d want 1", row_index); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL idle2_tx_valid got %b want 0", tx_valid); end
    endtask

    task automatic test_reset_mid_row();
        logic [7:0] exp;
        do_reset();
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_byte(8'hC0);
        pulse_row_done();
        tx_ready = 1'b0;
        send_byte(8'hD0);
        send_byte(8'hD1);
        send_byte(8'hEE);
        do_reset();
        send_byte(8'h50);
        send_byte(8'h51);
        checks++; if (row_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_partial got %b want 0", row_ready); end
        send_byte(8'h52);
        send_byte(8'h53);
        checks++; if (row_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b want 1", row_ready); end
        checks++; if (row_index !== 2'd0) begin errors++; $display("FAIL rst_mid_index got %0d want 0", row_index); end
        for (int a = 0; a < 4; a++) begin
            rd_addr = ADDR_W'(a);
            step();
            exp = 8'h50 + 8'(a);
            checks++; if (rd_data !== exp) begin errors++; $display("FAIL rst_mid_read[%0d] got %h want %h", a, rd_data, exp); end
        end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_mid_overrun got %b want 0", overrun); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_ack got %b want 0", tx_valid); end
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_overrun();
        test_ack_handshake();
        test_frame();
        test_back_to_back();
        test_idle_row_done();
        test_reset_mid_row();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_row_pingpong
